// File: rtl/dma_utils_pkg.sv
// dma_utils_pkg: shared types and helpers for the DMA descriptor scheduler and its streamers
//   dma_sched_st_t    : scheduler FSM states
//   s_dma_burst_req_t : burst request (address, byte length) at the widest supported sizes
//   burst_len()       : bytes in the next burst, min(remaining, max_burst)
package dma_utils_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        DRAIN,
        DONE
    } dma_sched_st_t;

    localparam int DMA_ADDR_W_MAX = 64;
    localparam int DMA_LEN_W_MAX  = 32;

    typedef struct packed {
        logic [DMA_ADDR_W_MAX-1:0] addr;
        logic [DMA_LEN_W_MAX-1:0]  len;
    } s_dma_burst_req_t;

    function automatic logic [DMA_LEN_W_MAX-1:0] burst_len(
        input logic [63:0] remaining,
        input int unsigned max_burst
    );
        return (remaining < 64'(max_burst)) ? remaining[DMA_LEN_W_MAX-1:0] : max_burst;
    endfunction

endpackage

// File: rtl/dma_outst_cnt.sv
// dma_outst_cnt: saturating up/down counter of outstanding burst pairs
//   clk, rst  : clock, synchronous active-high reset
//   inc       : one burst pair issued
//   dec       : one burst pair completed (ignored at zero)
//   cnt       : current outstanding count
//   empty     : cnt == 0
//   full_nxt  : count after this edge equals MAX_OUTST (no room for a new request)
module dma_outst_cnt #(
    parameter int MAX_OUTST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           inc,
    input  logic                           dec,
    output logic [$clog2(MAX_OUTST+1)-1:0] cnt,
    output logic                           empty,
    output logic                           full_nxt
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic             inc_ok, dec_ok, full;
    logic [CNT_W-1:0] nxt;

    always_comb begin
        full     = cnt == CNT_W'(MAX_OUTST);
        empty    = cnt == '0;
        dec_ok   = dec && !empty;
        inc_ok   = inc && (!full || dec_ok);
        nxt      = (inc_ok && !dec_ok) ? cnt + 1'b1 :
                   (dec_ok && !inc_ok) ? cnt - 1'b1 : cnt;
        full_nxt = nxt == CNT_W'(MAX_OUTST);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= nxt;
    end

endmodule

// File: rtl/dma_desc_sched.sv
// dma_desc_sched: walks the descriptor table, splits each transfer into bursts and
// issues paired read/write burst requests while tracking outstanding pairs.
//   clk, rst                    : clock, synchronous active-high reset
//   go_i, abort_i               : start pulse (IDLE only), stop issuing and drain
//   desc_en_i/src/dst/bytes     : flattened descriptor table, index 0 in the low slice
//   rd_req_* / wr_req_*         : valid/ready burst request channels to the streamers
//   txn_done_i, txn_err_i       : burst pair completion, AXI error
//   busy_o, done_o, error_o     : status to the CSRs
//   cur_desc_o, pend_txn_o      : current descriptor index, outstanding pair count
module dma_desc_sched
    import dma_utils_pkg::*;
#(
    parameter  int NUM_DESC        = 2,
    parameter  int ADDR_W          = 32,
    parameter  int BYTES_W         = 32,
    parameter  int MAX_BURST_BYTES = 256,
    parameter  int MAX_OUTST       = 4,
    localparam int LEN_W           = $clog2(MAX_BURST_BYTES) + 1,
    localparam int IDX_W           = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1,
    localparam int CNT_W           = $clog2(MAX_OUTST + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        go_i,
    input  logic                        abort_i,
    input  logic [NUM_DESC-1:0]         desc_en_i,
    input  logic [NUM_DESC*ADDR_W-1:0]  desc_src_i,
    input  logic [NUM_DESC*ADDR_W-1:0]  desc_dst_i,
    input  logic [NUM_DESC*BYTES_W-1:0] desc_bytes_i,
    output logic                        rd_req_valid_o,
    input  logic                        rd_req_ready_i,
    output logic [ADDR_W-1:0]           rd_req_addr_o,
    output logic [LEN_W-1:0]            rd_req_len_o,
    output logic                        wr_req_valid_o,
    input  logic                        wr_req_ready_i,
    output logic [ADDR_W-1:0]           wr_req_addr_o,
    output logic [LEN_W-1:0]            wr_req_len_o,
    input  logic                        txn_done_i,
    input  logic                        txn_err_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [IDX_W-1:0]            cur_desc_o,
    output logic [CNT_W-1:0]            pend_txn_o
);

    dma_sched_st_t state, state_nxt;

    logic [IDX_W-1:0]   idx;
    logic [ADDR_W-1:0]  src, dst;
    logic [BYTES_W-1:0] rem, rem_after;
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   pend;
    logic req_act, rd_acc, wr_acc, stop;
    logic rd_fire, wr_fire, issue, hold, stop_now, can_start, sel_hit, last_idx;
    logic empty, full_nxt;

    dma_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_outst (
        .clk      (clk),
        .rst      (rst),
        .inc      (issue),
        .dec      (txn_done_i),
        .cnt      (pend),
        .empty    (empty),
        .full_nxt (full_nxt)
    );

    // Burst datapath. req_act means a request pair is presented; each side drops
    // its valid once accepted and the pair issues when the later side is accepted.
    // A presented request is never withdrawn, so hold overrides stop.
    always_comb begin
        len       = LEN_W'(burst_len(64'(rem), MAX_BURST_BYTES));
        rd_fire   = rd_req_valid_o && rd_req_ready_i;
        wr_fire   = wr_req_valid_o && wr_req_ready_i;
        issue     = req_act && (rd_acc || rd_fire) && (wr_acc || wr_fire);
        hold      = req_act && !issue;
        rem_after = issue ? rem - BYTES_W'(len) : rem;
        stop_now  = stop || (txn_err_i && state != IDLE) ||
                    (abort_i && (state == SELECT || state == ISSUE));
        can_start = state == ISSUE && !hold && !stop_now && rem_after != '0 && !full_nxt;
        sel_hit   = desc_en_i[idx] && desc_bytes_i[32'(idx)*BYTES_W +: BYTES_W] != '0;
        last_idx  = idx == IDX_W'(NUM_DESC - 1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = go_i ? SELECT : IDLE;
            SELECT:  state_nxt = stop_now ? DRAIN : sel_hit ? ISSUE : last_idx ? DRAIN : SELECT;
            ISSUE:   state_nxt = hold ? ISSUE : stop_now ? DRAIN :
                                 (rem_after != '0) ? ISSUE : last_idx ? DRAIN : SELECT;
            DRAIN:   state_nxt = empty ? DONE : DRAIN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            src     <= '0;
            dst     <= '0;
            rem     <= '0;
            req_act <= 1'b0;
            rd_acc  <= 1'b0;
            wr_acc  <= 1'b0;
            stop    <= 1'b0;
            error_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            req_act <= hold || can_start;
            rd_acc  <= hold && (rd_acc || rd_fire);
            wr_acc  <= hold && (wr_acc || wr_fire);
            stop    <= state != IDLE && stop_now;
            if (state == IDLE && go_i) idx <= '0;
            else if (state_nxt == SELECT) idx <= idx + 1'b1;
            if (state == SELECT && state_nxt == ISSUE) begin
                src <= desc_src_i[32'(idx)*ADDR_W +: ADDR_W];
                dst <= desc_dst_i[32'(idx)*ADDR_W +: ADDR_W];
                rem <= desc_bytes_i[32'(idx)*BYTES_W +: BYTES_W];
            end else if (issue) begin
                src <= src + ADDR_W'(len);
                dst <= dst + ADDR_W'(len);
                rem <= rem_after;
            end
            if (state == IDLE && go_i) error_o <= 1'b0;
            else if (state != IDLE && txn_err_i) error_o <= 1'b1;
        end
    end

    always_comb begin
        busy_o         = state != IDLE;
        done_o         = state == DONE;
        rd_req_valid_o = req_act && !rd_acc;
        wr_req_valid_o = req_act && !wr_acc;
        rd_req_addr_o  = src;
        wr_req_addr_o  = dst;
        rd_req_len_o   = len;
        wr_req_len_o   = len;
        cur_desc_o     = idx;
        pend_txn_o     = pend;
    end

endmodule

// File: tb/tb_dma_desc_sched.sv
// tb_dma_desc_sched: randomized self-checking bench for dma_desc_sched against a burst-list model
module tb_dma_desc_sched;

    localparam int ND = 2;
    localparam int AW = 32;
    localparam int BW = 32;
    localparam int MB = 256;
    localparam int LW = 9;
    localparam int IW = 1;
    localparam int CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, go, abort_s, rd_ready, wr_ready, txn_done, txn_err;
    logic [ND-1:0]    en;
    logic [ND*AW-1:0] srcs, dsts;
    logic [ND*BW-1:0] bytes;
    logic             rd_valid, wr_valid, busy, done, error;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic [LW-1:0]    rd_len, wr_len;
    logic [IW-1:0]    cur_desc;
    logic [CW-1:0]    pend_txn;

    dma_desc_sched dut (
        .clk(clk), .rst(rst), .go_i(go), .abort_i(abort_s),
        .desc_en_i(en), .desc_src_i(srcs), .desc_dst_i(dsts), .desc_bytes_i(bytes),
        .rd_req_valid_o(rd_valid), .rd_req_ready_i(rd_ready),
        .rd_req_addr_o(rd_addr), .rd_req_len_o(rd_len),
        .wr_req_valid_o(wr_valid), .wr_req_ready_i(wr_ready),
        .wr_req_addr_o(wr_addr), .wr_req_len_o(wr_len),
        .txn_done_i(txn_done), .txn_err_i(txn_err),
        .busy_o(busy), .done_o(done), .error_o(error),
        .cur_desc_o(cur_desc), .pend_txn_o(pend_txn)
    );

    logic [AW+LW-1:0] rd_log[$], wr_log[$], exp_rd[$], exp_wr[$];
    logic [AW+LW-1:0] rd_prev, wr_prev;
    int  done_q[$];
    int  checks, errors, cyc, pend_m, rd_n, wr_n, hold_viol, pend_viol, done_cnt;
    int  lat_lo, lat_hi, done_mode;
    bit  rnd_rdy, pend_chk, rd_hold, wr_hold;

    // One clock cycle: drive automatic inputs at the negedge, observe the
    // handshakes that the coming posedge will complete, and advance the model.
    task automatic tick();
        int old_p, new_p;
        bit dec;
        if (rnd_rdy) begin
            rd_ready = ($urandom_range(0, 3) != 0);
            wr_ready = ($urandom_range(0, 3) != 0);
        end
        if (done_mode == 1) begin
            txn_done = (done_q.size() > 0 && done_q[0] <= cyc);
            if (txn_done) void'(done_q.pop_front());
        end else if (done_mode == 2) txn_done = 1'b1;
        #1;
        if (pend_chk && pend_txn !== CW'(pend_m)) pend_viol++;
        if (rd_hold && (rd_valid !== 1'b1 || {rd_addr, rd_len} !== rd_prev)) hold_viol++;
        if (wr_hold && (wr_valid !== 1'b1 || {wr_addr, wr_len} !== wr_prev)) hold_viol++;
        if (done === 1'b1) done_cnt++;
        if (rst) begin
            pend_m = 0; rd_n = 0; wr_n = 0; rd_hold = 0; wr_hold = 0;
            done_q.delete();
        end else begin
            old_p = (rd_n < wr_n) ? rd_n : wr_n;
            if (rd_valid === 1'b1 && rd_ready) begin rd_log.push_back({rd_addr, rd_len}); rd_n++; end
            if (wr_valid === 1'b1 && wr_ready) begin wr_log.push_back({wr_addr, wr_len}); wr_n++; end
            new_p = (rd_n < wr_n) ? rd_n : wr_n;
            dec = txn_done && pend_m > 0;
            pend_m = pend_m + ((new_p > old_p) ? 1 : 0) - (dec ? 1 : 0);
            if (new_p > old_p) done_q.push_back(cyc + $urandom_range(lat_lo, lat_hi));
            rd_hold = rd_valid === 1'b1 && !rd_ready;
            wr_hold = wr_valid === 1'b1 && !wr_ready;
            rd_prev = {rd_addr, rd_len};
            wr_prev = {wr_addr, wr_len};
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_desc(input int i, input bit e, input logic [31:0] s, d, b);
        en[i] = e;
        srcs[i*AW +: AW] = s;
        dsts[i*AW +: AW] = d;
        bytes[i*BW +: BW] = b;
    endtask

    // Expected burst list: each enabled non-empty descriptor in index order,
    // chopped into MB-byte pieces with a short tail.
    task automatic build_exp();
        logic [31:0] s, d;
        int r, l;
        exp_rd.delete();
        exp_wr.delete();
        for (int i = 0; i < ND; i++) begin
            s = srcs[i*AW +: AW];
            d = dsts[i*AW +: AW];
            r = int'(bytes[i*BW +: BW]);
            if (!en[i]) r = 0;
            while (r > 0) begin
                l = (r > MB) ? MB : r;
                exp_rd.push_back({s, LW'(l)});
                exp_wr.push_back({d, LW'(l)});
                s = s + l; d = d + l; r = r - l;
            end
        end
    endtask

    task automatic clear_logs();
        rd_log.delete(); wr_log.delete();
        done_cnt = 0; hold_viol = 0; pend_viol = 0;
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin tick(); n++; end
        repeat (3) tick();
    endtask

    function automatic int log_errs();
        int e = 0;
        if (rd_log.size() != exp_rd.size()) e++;
        if (wr_log.size() != exp_wr.size()) e++;
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++) if (rd_log[i] !== exp_rd[i]) e++;
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) if (wr_log[i] !== exp_wr[i]) e++;
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if ({rd_valid, wr_valid, busy, done, error} !== 5'b0) begin errors++;
            $display("FAIL reset_flags: got %b expected 00000", {rd_valid, wr_valid, busy, done, error}); end
        checks++; if (pend_txn !== '0) begin errors++;
            $display("FAIL reset_pend: got %0d expected 0", pend_txn); end
        checks++; if ({cur_desc, rd_addr, wr_addr, rd_len, wr_len} !== '0) begin errors++;
            $display("FAIL reset_data: got %0h expected 0", {cur_desc, rd_addr, wr_addr, rd_len, wr_len}); end
        rst = 1'b0;
        tick();
        pend_chk = 1;
    endtask

    task automatic test_basic();
        set_desc(0, 1, 32'h1000, 32'h2000, 600);
        set_desc(1, 0, 32'h9000, 32'h9800, 64);
        rnd_rdy = 0; rd_ready = 1; wr_ready = 1;
        done_mode = 1; lat_lo = 4; lat_hi = 4;
        clear_logs(); build_exp();
        go = 1; tick(); go = 0;
        run_to_done(200);
        checks++; if (rd_log.size() != 3) begin errors++;
            $display("FAIL basic_count: got %0d bursts expected 3", rd_log.size()); end
        checks++; if (log_errs() != 0) begin errors++;
            $display("FAIL basic_bursts: got %0d mismatches expected 0", log_errs()); end
        checks++; if (done_cnt != 1) begin errors++;
            $display("FAIL basic_done: got %0d pulses expected 1", done_cnt); end
        checks++; if ({error, busy, pend_txn} !== '0) begin errors++;
            $display("FAIL basic_end: got err/busy/pend %0h expected 0", {error, busy, pend_txn}); end
        checks++; if (pend_viol + hold_viol != 0) begin errors++;
            $display("FAIL basic_protocol: got %0d/%0d pend/hold violations expected 0", pend_viol, hold_viol); end
    endtask

    task automatic test_backpressure();
        logic [AW+LW-1:0] w0;
        int n = 0;
        set_desc(0, 1, 32'h3000, 32'h4000, 256);
        set_desc(1, 0, 0, 0, 0);
        rnd_rdy = 0; rd_ready = 1; wr_ready = 0;
        done_mode = 1; lat_lo = 2; lat_hi = 2;
        clear_logs(); build_exp();
        go = 1; tick(); go = 0;
        while (wr_valid !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (wr_valid !== 1'b1) begin errors++;
            $display("FAIL bp_valid_rise: got %b expected 1 within 10 cycles", wr_valid); end
        w0 = {wr_addr, wr_len};
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if ({rd_valid, wr_valid} !== 2'b01) begin errors++;
                $display("FAIL bp_valids[%0d]: got rd/wr %b expected 01", k, {rd_valid, wr_valid}); end
            checks++; if ({wr_addr, wr_len} !== w0 || pend_txn !== '0) begin errors++;
                $display("FAIL bp_stable[%0d]: got %0h pend %0d expected %0h pend 0", k, {wr_addr, wr_len}, pend_txn, w0); end
        end
        wr_ready = 1;
        tick();
        checks++; if (pend_txn !== CW'(1) || wr_valid !== 1'b0) begin errors++;
            $display("FAIL bp_issue: got pend %0d wr_valid %b expected 1 0", pend_txn, wr_valid); end
        run_to_done(100);
        checks++; if (log_errs() != 0 || done_cnt != 1 || hold_viol != 0 || pend_viol != 0) begin errors++;
            $display("FAIL bp_result: got %0d mismatches %0d dones %0d/%0d viol expected 0 1 0/0",
                     log_errs(), done_cnt, hold_viol, pend_viol); end
    endtask

    task automatic test_outstanding();
        set_desc(0, 1, 32'h10000, 32'h20000, 2048);
        set_desc(1, 0, 0, 0, 0);
        rnd_rdy = 0; rd_ready = 1; wr_ready = 1;
        done_mode = 0; txn_done = 0;
        clear_logs(); build_exp();
        go = 1; tick(); go = 0;
        repeat (30) tick();
        checks++; if (rd_log.size() != 4 || wr_log.size() != 4) begin errors++;
            $display("FAIL outst_cap: got %0d/%0d bursts expected 4/4", rd_log.size(), wr_log.size()); end
        checks++; if (pend_txn !== CW'(4) || {rd_valid, wr_valid} !== 2'b00) begin errors++;
            $display("FAIL outst_stall: got pend %0d valids %b expected 4 00", pend_txn, {rd_valid, wr_valid}); end
        txn_done = 1; tick(); txn_done = 0;
        repeat (5) tick();
        checks++; if (rd_log.size() != 5 || pend_txn !== CW'(4)) begin errors++;
            $display("FAIL outst_refill: got %0d bursts pend %0d expected 5 4", rd_log.size(), pend_txn); end
        done_mode = 2;
        run_to_done(200);
        done_mode = 0; txn_done = 0;
        checks++; if (log_errs() != 0 || done_cnt != 1 || pend_viol != 0) begin errors++;
            $display("FAIL outst_result: got %0d mismatches %0d dones %0d pend viol expected 0 1 0",
                     log_errs(), done_cnt, pend_viol); end
    endtask

    task automatic test_no_desc();
        int n = 1;
        set_desc(0, 0, 32'h100, 32'h200, 512);
        set_desc(1, 1, 32'h300, 32'h400, 0);
        clear_logs();
        go = 1; tick(); go = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n != 4) begin errors++;
            $display("FAIL nodesc_latency: got done after %0d cycles expected 4", n); end
        tick();
        checks++; if (rd_log.size() + wr_log.size() != 0 || {busy, done} !== 2'b00) begin errors++;
            $display("FAIL nodesc_idle: got %0d requests busy/done %b expected 0 00",
                     rd_log.size() + wr_log.size(), {busy, done}); end
    endtask

    task automatic test_error();
        int n = 0;
        set_desc(0, 1, 32'h5000, 32'h6000, 1024);
        set_desc(1, 0, 0, 0, 0);
        rnd_rdy = 0; rd_ready = 1; wr_ready = 1;
        done_mode = 1; lat_lo = 3; lat_hi = 3;
        clear_logs(); build_exp();
        go = 1; tick(); go = 0;
        while (rd_log.size() < 1 && n < 50) begin tick(); n++; end
        checks++; if (rd_valid !== 1'b1) begin errors++;
            $display("FAIL err_second_burst: got rd_valid %b expected 1", rd_valid); end
        txn_err = 1; tick(); txn_err = 0;
        run_to_done(100);
        checks++; if (rd_log.size() != 2 || wr_log.size() != 2) begin errors++;
            $display("FAIL err_count: got %0d/%0d bursts expected 2/2", rd_log.size(), wr_log.size()); end
        checks++; if (rd_log.size() == 2 && (rd_log[1] !== exp_rd[1] || wr_log[1] !== exp_wr[1])) begin errors++;
            $display("FAIL err_burst2: got %0h expected %0h", rd_log[1], exp_rd[1]); end
        checks++; if (error !== 1'b1 || done_cnt != 1 || pend_txn !== '0) begin errors++;
            $display("FAIL err_end: got error %b dones %0d pend %0d expected 1 1 0", error, done_cnt, pend_txn); end
        clear_logs();
        go = 1; tick(); go = 0;
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL err_clear: got error %b busy %b expected 0 1", error, busy); end
        run_to_done(200);
        checks++; if (log_errs() != 0 || done_cnt != 1 || error !== 1'b0) begin errors++;
            $display("FAIL err_rerun: got %0d mismatches %0d dones error %b expected 0 1 0",
                     log_errs(), done_cnt, error); end
    endtask

    task automatic test_abort_reset();
        int n = 0;
        set_desc(0, 1, 32'hFFFF_FF00, 32'h7000, 2048);
        set_desc(1, 1, 32'h0000_8000, 32'hFFFF_FFC0, 300);
        rnd_rdy = 0; rd_ready = 1; wr_ready = 1;
        done_mode = 0; txn_done = 0;
        clear_logs();
        go = 1; tick(); go = 0;
        while (rd_log.size() < 2 && n < 50) begin tick(); n++; end
        abort_s = 1; tick(); abort_s = 0;
        repeat (3) tick();
        checks++; if (rd_log.size() != 3 || busy !== 1'b1 || rd_valid !== 1'b0) begin errors++;
            $display("FAIL abort_drain: got %0d bursts busy %b valid %b expected 3 1 0", rd_log.size(), busy, rd_valid); end
        checks++; if (pend_txn !== CW'(3) || error !== 1'b0) begin errors++;
            $display("FAIL abort_state: got pend %0d error %b expected 3 0", pend_txn, error); end
        rst = 1; tick(); rst = 0;
        checks++; if ({rd_valid, wr_valid, busy, done, error, pend_txn, cur_desc} !== '0) begin errors++;
            $display("FAIL abort_reset: got %0h expected 0", {rd_valid, wr_valid, busy, done, error, pend_txn, cur_desc}); end
        checks++; if (done_cnt != 0) begin errors++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt); end
        rnd_rdy = 1; done_mode = 1; lat_lo = 1; lat_hi = 6;
        clear_logs(); build_exp();
        go = 1; tick(); go = 0;
        run_to_done(2000);
        checks++; if (log_errs() != 0 || done_cnt != 1 || error !== 1'b0) begin errors++;
            $display("FAIL abort_rerun: got %0d mismatches %0d dones error %b expected 0 1 0",
                     log_errs(), done_cnt, error); end
        checks++; if (pend_viol + hold_viol != 0) begin errors++;
            $display("FAIL abort_protocol: got %0d/%0d pend/hold violations expected 0", pend_viol, hold_viol); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < ND; i++)
                set_desc(i, $urandom_range(0, 3) != 0, $urandom, $urandom,
                         ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 1100));
            rnd_rdy = 1; done_mode = 1; lat_lo = 1; lat_hi = 8;
            clear_logs(); build_exp();
            go = 1; tick(); go = 0;
            run_to_done(3000);
            checks++; if (log_errs() != 0) begin errors++;
                $display("FAIL rand%0d_bursts: got %0d mismatches expected 0", it, log_errs()); end
            checks++; if (done_cnt != 1 || {error, busy, pend_txn} !== '0) begin errors++;
                $display("FAIL rand%0d_end: got %0d dones err/busy/pend %0h expected 1 0", it, done_cnt, {error, busy, pend_txn}); end
            checks++; if (pend_viol + hold_viol != 0) begin errors++;
                $display("FAIL rand%0d_protocol: got %0d/%0d pend/hold violations expected 0", it, pend_viol, hold_viol); end
        end
    endtask

    initial begin
        rst = 1; go = 0; abort_s = 0; rd_ready = 0; wr_ready = 0; txn_done = 0; txn_err = 0;
        en = '0; srcs = '0; dsts = '0; bytes = '0;
        checks = 0; errors = 0; cyc = 0; pend_m = 0; rd_n = 0; wr_n = 0;
        hold_viol = 0; pend_viol = 0; done_cnt = 0; lat_lo = 1; lat_hi = 1; done_mode = 0;
        rnd_rdy = 0; pend_chk = 0; rd_hold = 0; wr_hold = 0; rd_prev = '0; wr_prev = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_outstanding();
        test_no_desc();
        test_error();
        test_abort_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
